pio_in_capture: RTL and testbench
=================================

# pio_in_capture

Parametrised Avalon-MM input port and successor to the 8-bit input PIO. Samples a WIDTH-bit external bus through a synchroniser and an optional per-bit debouncer. Latches qualifying edges into a sticky capture register and raises a level interrupt through a per-bit mask. It sits on the CPU data bus next to the other PIO slaves, with one read-wait cycle (readdata registered).

## Interface
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (≥2).
- DEBOUNCE_CYCLES, 0, stable cycles required before a bit changes; 0 bypasses the debouncer.
- EDGE_MODE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave selected.
- write_n  in  1  active-low write strobe, valid with chipselect.
- writedata  in  WIDTH  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  WIDTH  registered read data.
- irq  out  1  level interrupt, registered.

## Operation
- Register map. Unused bits read 0.
  - addr 0 DATA: RO, filtered input value.
  - addr 1: reads 0, writes ignored.
  - addr 2 IRQMASK: RW.
  - addr 3 EDGECAP: read; write-1-to-clear per bit.
- Pipeline per bit: SYNC_STAGES flop chain → debouncer → filtered value `f`. `f_d` is `f` delayed one cycle.
- Debouncer, per bit:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Sync output ≠ `f`: counter increments. Counter reaching DEBOUNCE_CYCLES−1 while still different: `f` toggles and the counter clears.
  - Sync output = `f`: counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach `f`.
- Edge detect: rise = f & ~f_d; fall = ~f & f_d; selected per EDGE_MODE.
- EDGECAP[i]:
  - Sets on a selected edge.
  - Clears when a write to addr 3 has writedata[i]=1.
  - Set and clear on the same cycle: set wins and the bit stays 1.
- irq is registered: irq <= |(EDGECAP & IRQMASK). The next-state EDGECAP is not used.
- Read mux uses address only (no chipselect gating), matching the existing PIO behaviour. readdata <= mux(address) every cycle.
- Writes occur when chipselect & ~write_n. Writes to addr 0 and 1 have no effect.

## Timing
- Reset values, all 0: readdata, irq, IRQMASK, EDGECAP, sync chain, `f`, `f_d`, debounce counters. Reset mid-operation clears everything asynchronously with no spurious edge after release, because `f` and `f_d` are both 0.
- in_port change to `f` change: SYNC_STAGES + DEBOUNCE_CYCLES cycles (+0/1 cycle metastability uncertainty).
- `f` change to EDGECAP set: 1 cycle. EDGECAP to irq: 1 cycle.
- Read latency: 1 cycle, with readdata valid the cycle after address is presented. A read of EDGECAP in the same cycle as a clear returns the pre-clear value.
- Write to IRQMASK affects irq 2 cycles later: mask register, then irq flop.
- Input toggling every cycle with DEBOUNCE_CYCLES=0: each qualifying edge sets capture; further edges while a bit is set are absorbed (sticky).
- Debounce counter cannot overflow, because it clears at the terminal count.

## Structure
- Shared package `pio_pkg`:
  - Register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3.
  - EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
- Sub-module `pio_bit_filter`, instantiated WIDTH times in a generate loop. It holds the per-bit synchroniser, debouncer and edge detect, and outputs `f` and an edge pulse. The top holds registers, read mux and irq.

## Test plan
- Reset: assert reset mid-traffic with EDGECAP=0xFF → readdata, irq, IRQMASK, EDGECAP all 0 immediately. No capture after release with in_port=0x00.
- DATA path, WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=0: in_port 0x00→0xA5 → DATA read returns 0xA5 from the 3rd cycle after the change, readdata one cycle after address.
- Debounce with DEBOUNCE_CYCLES=4:
  - Bit 0 pulsed high for 3 cycles → DATA stays 0x00, EDGECAP stays 0.
  - Held high for 4 or more cycles → DATA bit 0 = 1 after 2+4 cycles.
- Edge/irq with EDGE_MODE=0, IRQMASK=0x01: rising edge on bit 0 → EDGECAP=0x01, then irq=1 one cycle later. A falling edge does not set capture.
- W1C race: write 0x01 to addr 3 on the same cycle a new edge sets bit 0 → EDGECAP bit 0 stays 1 and irq stays 1. A write of 0x01 with no edge → EDGECAP=0 and irq=0 two cycles later.
- Mask and EDGE_MODE=2: edges on bits 3 and 5 with IRQMASK=0x08 → EDGECAP=0x28 and irq=1. Write IRQMASK=0x00 → irq=0 after 2 cycles while EDGECAP holds 0x28.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO input-capture slave: register map and edge-mode encodings.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Picks the qualifying edge for a given EDGE_MODE parameter value.
    function automatic logic edge_sel(input int mode, input logic rise, input logic fall);
        if (mode == int'(EDGE_RISE))
            return rise;
        else if (mode == int'(EDGE_FALL))
            return fall;
        else
            return rise | fall;
    endfunction

endpackage

// File: rtl/pio_bit_filter.sv
// One input bit: synchroniser chain, optional debouncer, and edge detect on the filtered value.
module pio_bit_filter
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic f,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   f_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], pin};
    end

    assign s = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign f = s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;
            logic          f_q;

            // Counter clears at the terminal count, so it never wraps.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    f_q <= 1'b0;
                end else if (s == f_q) begin
                    cnt <= '0;
                end else if (cnt == TERM) begin
                    f_q <= ~f_q;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign f = f_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            f_d <= 1'b0;
        else
            f_d <= f;
    end

    assign edge_pulse = edge_sel(EDGE_MODE, f & ~f_d, ~f & f_d);

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input port: filtered inputs, sticky edge capture with W1C, masked level irq.
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_mux;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_bit_filter #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE)
        ) u_filt (
            .clk       (clk),
            .rst       (reset),
            .pin       (in_port[i]),
            .f         (f[i]),
            .edge_pulse(edges[i])
        );
    end

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == ADDR_EDGE) ? writedata : '0;

    // Read mux ignores chipselect so readdata tracks address every cycle.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = f;
            ADDR_RSVD: rd_mux = '0;
            ADDR_MASK: rd_mux = mask;
            ADDR_EDGE: rd_mux = edgecap;
            default:   rd_mux = '0;
        endcase
    end

    // A new edge overrides a simultaneous clear; irq uses the current capture value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr && address == ADDR_MASK)
                mask <= writedata;
            edgecap  <= (edgecap & ~clr) | edges;
            irq      <= |(edgecap & mask);
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench: ua uses no debounce / rising edges, ub uses a 4-cycle debounce / any edge.
module tb_pio_in_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [7:0] writedata = 8'h00;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [7:0] rd_a, rd_b;
    logic       irq_a, irq_b;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) ua (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) ub (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("reset_rd_a", rd_a, 8'h00);
        chk("reset_irq_a", {7'd0, irq_a}, 8'h00);
        chk("reset_rd_b", rd_b, 8'h00);
        chk("reset_irq_b", {7'd0, irq_b}, 8'h00);

        // DATA path latency, rising capture, W1C, no capture on falling edge
        address = 2'd0;
        in_a = 8'hA5;
        tick(2);
        chk("data_early", rd_a, 8'h00);
        tick(1);
        chk("data", rd_a, 8'hA5);
        rd(2'd3);
        chk("cap_rise", rd_a, 8'hA5);
        chk("irq_masked", {7'd0, irq_a}, 8'h00);
        wr(2'd3, 8'hFF);
        rd(2'd3);
        chk("w1c_all", rd_a, 8'h00);
        in_a = 8'h00;
        tick(4);
        chk("no_fall_cap", rd_a, 8'h00);
        wr(2'd1, 8'hFF);
        rd(2'd1);
        chk("rsvd", rd_a, 8'h00);
        wr(2'd2, 8'h01);
        rd(2'd2);
        chk("mask_rw", rd_a, 8'h01);

        // edge -> capture -> irq timing
        in_a = 8'h01;
        tick(3);
        chk("irq_early", {7'd0, irq_a}, 8'h00);
        tick(1);
        chk("irq_rise", {7'd0, irq_a}, 8'h01);
        rd(2'd3);
        chk("cap_bit0", rd_a, 8'h01);
        in_a = 8'h00;
        tick(4);
        chk("irq_sticky", {7'd0, irq_a}, 8'h01);

        // clear lands on the same edge that sets bit 0
        in_a = 8'h01;
        tick(2);
        wr(2'd3, 8'h01);
        tick(1);
        chk("race_irq", {7'd0, irq_a}, 8'h01);
        rd(2'd3);
        chk("race_cap", rd_a, 8'h01);
        wr(2'd3, 8'h01);
        chk("rd_preclear", rd_a, 8'h01);
        chk("irq_lag", {7'd0, irq_a}, 8'h01);
        tick(1);
        chk("irq_clr", {7'd0, irq_a}, 8'h00);
        rd(2'd3);
        chk("cap_clr", rd_a, 8'h00);

        // debounce: 3-cycle glitch rejected, 4-cycle hold accepted
        address = 2'd0;
        in_b = 8'h01;
        tick(3);
        in_b = 8'h00;
        tick(6);
        chk("glitch_data", rd_b, 8'h00);
        rd(2'd3);
        chk("glitch_cap", rd_b, 8'h00);
        address = 2'd0;
        in_b = 8'h01;
        tick(6);
        chk("db_early", rd_b, 8'h00);
        tick(1);
        chk("db_hold", rd_b, 8'h01);

        // any-edge capture with mask on bit 3 only
        wr(2'd2, 8'h08);
        wr(2'd3, 8'hFF);
        in_b = 8'h29;
        tick(9);
        rd(2'd3);
        chk("cap_any", rd_b, 8'h28);
        chk("irq_any", {7'd0, irq_b}, 8'h01);
        wr(2'd2, 8'h00);
        chk("mask_lag", {7'd0, irq_b}, 8'h01);
        tick(1);
        chk("mask_off", {7'd0, irq_b}, 8'h00);
        rd(2'd3);
        chk("cap_hold", rd_b, 8'h28);
        wr(2'd3, 8'h20);
        in_b = 8'h09;
        tick(9);
        rd(2'd3);
        chk("cap_fall_any", rd_b, 8'h28);

        // asynchronous reset mid-traffic
        in_a = 8'h00;
        tick(4);
        in_a = 8'hFF;
        tick(4);
        wr(2'd2, 8'hFF);
        rd(2'd3);
        chk("pre_rst_cap", rd_a, 8'hFF);
        tick(1);
        chk("pre_rst_irq", {7'd0, irq_a}, 8'h01);
        reset = 1'b1;
        #1;
        chk("rst_rd", rd_a, 8'h00);
        chk("rst_irq", {7'd0, irq_a}, 8'h00);
        in_a = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(5);
        rd(2'd2);
        chk("rst_mask", rd_a, 8'h00);
        rd(2'd3);
        chk("rst_cap", rd_a, 8'h00);
        chk("rst_no_irq", {7'd0, irq_a}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
